// File: rtl/mastermind_pkg.sv
// Shared types and sizing for the mastermind scorer.
package mastermind_pkg;

    localparam int COLOR_W    = 3;
    localparam int NUM_DIGITS = 4;
    localparam int NUM_COLORS = 8;

    typedef logic [NUM_DIGITS-1:0][COLOR_W-1:0] code_t;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        EXACT,
        COLOR,
        REPORT,
        WON,
        LOST
    } state_t;

    function automatic logic [2:0] min3(input logic [2:0] a,
                                        input logic [2:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/mastermind_color_count.sv
// Counts how many digits of a code carry a given colour.
module mastermind_color_count
    import mastermind_pkg::*;
(
    input  code_t              code,
    input  logic [COLOR_W-1:0] color,
    output logic [2:0]         count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (code[i] == color) count = count + 3'd1;
        end
    end

endmodule

// File: rtl/mastermind_scorer.sv
// Sequential mastermind scorer: 4 cycles of exact matching,
// 8 cycles of per-colour common counting, then a report.
module mastermind_scorer
    import mastermind_pkg::*;
#(
    parameter int MAX_GUESSES = 8
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        secret_load,
    input  logic [11:0] secret,
    input  logic        guess_valid,
    input  logic [11:0] guess,
    output logic        guess_ready,
    output logic        score_valid,
    output logic [2:0]  exact,
    output logic [2:0]  partial,
    output logic [3:0]  attempts,
    output logic        win,
    output logic        lose
);

    state_t             state;
    code_t              sec_q;
    code_t              gss_q;
    logic [1:0]         idx;
    logic [COLOR_W-1:0] col;
    logic [2:0]         ex_cnt;
    logic [2:0]         com_cnt;
    logic [2:0]         sec_n;
    logic [2:0]         gss_n;
    logic [2:0]         com_next;

    mastermind_color_count u_sec_cnt (
        .code  (sec_q),
        .color (col),
        .count (sec_n)
    );

    mastermind_color_count u_gss_cnt (
        .code  (gss_q),
        .color (col),
        .count (gss_n)
    );

    assign com_next = com_cnt + min3(sec_n, gss_n);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            sec_q       <= '0;
            gss_q       <= '0;
            idx         <= '0;
            col         <= '0;
            ex_cnt      <= '0;
            com_cnt     <= '0;
            guess_ready <= 1'b0;
            score_valid <= 1'b0;
            exact       <= '0;
            partial     <= '0;
            attempts    <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else if (secret_load) begin
            // New game wins over everything, including an in-flight guess.
            state       <= READY;
            sec_q       <= secret;
            idx         <= '0;
            col         <= '0;
            ex_cnt      <= '0;
            com_cnt     <= '0;
            guess_ready <= 1'b1;
            score_valid <= 1'b0;
            exact       <= '0;
            partial     <= '0;
            attempts    <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            score_valid <= 1'b0;
            unique case (state)
                IDLE: ;
                READY: begin
                    if (guess_valid) begin
                        gss_q       <= guess;
                        idx         <= '0;
                        ex_cnt      <= '0;
                        guess_ready <= 1'b0;
                        state       <= EXACT;
                    end
                end
                EXACT: begin
                    if (gss_q[idx] == sec_q[idx]) ex_cnt <= ex_cnt + 3'd1;
                    idx <= idx + 2'd1;
                    if (idx == 2'(NUM_DIGITS - 1)) begin
                        col     <= '0;
                        com_cnt <= '0;
                        state   <= COLOR;
                    end
                end
                COLOR: begin
                    com_cnt <= com_next;
                    col     <= col + 3'd1;
                    if (col == 3'(NUM_COLORS - 1)) begin
                        state       <= REPORT;
                        score_valid <= 1'b1;
                        exact       <= ex_cnt;
                        partial     <= com_next - ex_cnt;
                        attempts    <= attempts + 4'd1;
                    end
                end
                REPORT: begin
                    if (exact == 3'd4) begin
                        win   <= 1'b1;
                        state <= WON;
                    end else if (attempts == 4'(MAX_GUESSES)) begin
                        lose  <= 1'b1;
                        state <= LOST;
                    end else begin
                        guess_ready <= 1'b1;
                        state       <= READY;
                    end
                end
                WON, LOST: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mastermind_scorer.sv
// Randomised and directed checks of the mastermind scorer
// against a histogram-based scoring model.
module tb_mastermind_scorer;

    localparam int MAXG = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        secret_load = 1'b0;
    logic [11:0] secret = '0;
    logic        guess_valid = 1'b0;
    logic [11:0] guess = '0;
    logic        guess_ready;
    logic        score_valid;
    logic [2:0]  exact;
    logic [2:0]  partial;
    logic [3:0]  attempts;
    logic        win;
    logic        lose;

    int          n_run = 0;
    int          n_fail = 0;
    logic [11:0] m_secret = '0;
    int          m_att = 0;
    bit          m_win = 0;
    bit          m_lose = 0;

    mastermind_scorer #(.MAX_GUESSES(MAXG)) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .secret_load (secret_load),
        .secret      (secret),
        .guess_valid (guess_valid),
        .guess       (guess),
        .guess_ready (guess_ready),
        .score_valid (score_valid),
        .exact       (exact),
        .partial     (partial),
        .attempts    (attempts),
        .win         (win),
        .lose        (lose)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pack(input int d0, input int d1,
                                         input int d2, input int d3);
        return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    function automatic void ref_score(input logic [11:0] s,
                                      input logic [11:0] g,
                                      output int ex, output int pa);
        int hs[8];
        int hg[8];
        int common;
        ex = 0;
        common = 0;
        for (int c = 0; c < 8; c++) begin
            hs[c] = 0;
            hg[c] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            int a;
            int b;
            a = int'(s[i*3 +: 3]);
            b = int'(g[i*3 +: 3]);
            if (a == b) ex++;
            hs[a]++;
            hg[b]++;
        end
        for (int c = 0; c < 8; c++)
            common += (hs[c] < hg[c]) ? hs[c] : hg[c];
        pa = common - ex;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, guess_ready, 0);
        check({tag, "_sv"}, score_valid, 0);
        check({tag, "_exact"}, exact, 0);
        check({tag, "_partial"}, partial, 0);
        check({tag, "_att"}, attempts, 0);
        check({tag, "_win"}, win, 0);
        check({tag, "_lose"}, lose, 0);
    endtask

    task automatic load(input logic [11:0] s);
        @(negedge clk);
        secret_load = 1'b1;
        secret = s;
        @(negedge clk);
        secret_load = 1'b0;
        m_secret = s;
        m_att = 0;
        m_win = 0;
        m_lose = 0;
        check("load_ready", guess_ready, 1);
        check("load_att", attempts, 0);
        check("load_exact", exact, 0);
        check("load_partial", partial, 0);
        check("load_winlose", {win, lose}, 0);
    endtask

    task automatic watch_no_score(input string tag, input int cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (score_valid) seen = 1;
        end
        check(tag, seen, 0);
    endtask

    // Offers one guess at a negedge and leaves the bench at a negedge.
    task automatic accept(input logic [11:0] g);
        guess_valid = 1'b1;
        guess = g;
        @(posedge clk);
        @(negedge clk);
        guess_valid = 1'b0;
    endtask

    task automatic score_guess(input logic [11:0] g);
        int ex;
        int pa;
        int n;
        bit seen;
        ref_score(m_secret, g, ex, pa);
        check("ready_before", guess_ready, 1);
        accept(g);
        n = 0;
        seen = score_valid;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = score_valid;
        end
        check("latency", n, 12);
        if (seen) begin
            m_att++;
            check("exact", exact, ex);
            check("partial", partial, pa);
            check("attempts", attempts, m_att);
            if (ex == 4) m_win = 1;
            else if (m_att == MAXG) m_lose = 1;
            @(negedge clk);
            check("sv_pulse", score_valid, 0);
            check("win", win, m_win);
            check("lose", lose, m_lose);
            check("ready_after", guess_ready, !(m_win || m_lose));
        end
    endtask

    initial begin
        #5 rst_n = 1'b0;
        #10;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        guess_valid = 1'b1;
        guess = pack(0, 0, 0, 0);
        watch_no_score("idle_ignore", 5);
        guess_valid = 1'b0;
        check("idle_ready", guess_ready, 0);

        // Exact win.
        load(pack(0, 1, 2, 3));
        score_guess(pack(0, 1, 2, 3));
        check("win_exact", exact, 4);
        check("win_partial", partial, 0);
        check("win_att", attempts, 1);
        check("win_flag", win, 1);
        repeat (3) @(negedge clk);
        check("win_ready_low", guess_ready, 0);
        check("win_held", win, 1);

        // All colours right, all places wrong.
        load(pack(0, 1, 2, 3));
        score_guess(pack(3, 2, 1, 0));
        check("perm_exact", exact, 0);
        check("perm_partial", partial, 4);
        check("perm_ready", guess_ready, 1);

        // Duplicates.
        load(pack(1, 1, 2, 2));
        score_guess(pack(1, 2, 1, 5));
        check("dup_exact", exact, 1);
        check("dup_partial", partial, 2);

        // Run out of guesses.
        load(pack(0, 1, 2, 3));
        for (int i = 0; i < MAXG; i++) score_guess(pack(7, 7, 7, 7));
        check("loss_flag", lose, 1);
        check("loss_att", attempts, MAXG);
        check("loss_ready", guess_ready, 0);
        guess_valid = 1'b1;
        watch_no_score("loss_ignore", 20);
        guess_valid = 1'b0;
        check("loss_att_hold", attempts, MAXG);
        check("loss_hold", lose, 1);

        // Abort scoring five edges after acceptance.
        load(pack(4, 5, 6, 7));
        score_guess(pack(4, 6, 5, 0));
        accept(pack(4, 5, 6, 7));
        repeat (4) @(negedge clk);
        secret_load = 1'b1;
        secret = pack(2, 2, 3, 3);
        guess_valid = 1'b1;
        @(negedge clk);
        secret_load = 1'b0;
        guess_valid = 1'b0;
        m_secret = pack(2, 2, 3, 3);
        m_att = 0;
        m_win = 0;
        m_lose = 0;
        check("abort_att", attempts, 0);
        check("abort_ready", guess_ready, 1);
        check("abort_exact", exact, 0);
        check("abort_partial", partial, 0);
        watch_no_score("abort_no_sv", 20);
        check("abort_ready2", guess_ready, 1);

        // Load and guess on the same READY edge: load wins.
        @(negedge clk);
        secret_load = 1'b1;
        secret = pack(6, 6, 6, 6);
        guess_valid = 1'b1;
        guess = pack(6, 6, 6, 6);
        @(negedge clk);
        secret_load = 1'b0;
        guess_valid = 1'b0;
        m_secret = pack(6, 6, 6, 6);
        watch_no_score("coload_no_sv", 20);
        check("coload_ready", guess_ready, 1);
        score_guess(pack(6, 1, 6, 6));

        // Reset in the middle of COLOR.
        accept(pack(0, 0, 0, 0));
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_score("midrst_no_sv", 20);
        check("midrst_idle", guess_ready, 0);

        // Random games.
        for (int gm = 0; gm < 30; gm++) begin
            load(12'($urandom));
            while (!m_win && !m_lose && n_fail < 50) begin
                if ($urandom_range(0, 3) == 0) score_guess(m_secret);
                else score_guess(12'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mastermind_scorer.md
MASTERMIND_SCORER -- requirements
Module: mastermind_scorer

Interface
REQ-001 SHALL have parameter MAX_GUESSES, default 8, meaning the number of scored guesses before loss; legal range 1..15.
REQ-002 SHALL have port CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port secret_load  in  1  load new secret code and start a new game.
REQ-005 SHALL have port secret  in  12  code; [2:0]=d0, [5:3]=d1, [8:6]=d2, [11:9]=d3, colours 0..7.
REQ-006 SHALL have port guess_valid  in  1  guess offered.
REQ-007 SHALL have port guess  in  12  guess, same packing as secret.
REQ-008 SHALL have port guess_ready  out  1  scorer accepts a guess this cycle.
REQ-009 SHALL have port score_valid  out  1  one-cycle pulse, exact/partial updated.
REQ-010 SHALL have port exact  out  3  digits with matching colour and position, 0..4.
REQ-011 SHALL have port partial  out  3  matching colour in the wrong position, 0..4.
REQ-012 SHALL have port attempts  out  4  guesses scored this game.
REQ-013 SHALL have ports win and lose  out  1 each  game outcome, held.

Function
REQ-014 SHALL implement states IDLE, READY, EXACT, COLOR, REPORT, WON, LOST.
REQ-015 IDLE: no secret held; guess_ready=0; secret_load -> READY.
REQ-016 READY: guess_ready=1; guess_valid&guess_ready on an edge captures guess -> EXACT, idx=0.
REQ-017 EXACT: one digit per cycle, idx 0..3; increments exact count on equal colour; after idx 3 -> COLOR, c=0.
REQ-018 COLOR: one colour per cycle, c 0..7; common += min(count of c in secret, count of c in guess); after c=7 -> REPORT.
REQ-019 partial SHALL equal common minus exact; results saturate at no width boundary (common never exceeds 4).
REQ-020 REPORT: score_valid=1 for exactly one cycle; exact/partial registered and held until next report or game reset; attempts increments by 1.
REQ-021 score_valid SHALL rise exactly 12 rising edges after the accepting edge.
REQ-022 REPORT -> WON if exact=4; else -> LOST if new attempts=MAX_GUESSES; else -> READY.
REQ-023 WON: win=1, guess_ready=0; LOST: lose=1, guess_ready=0; both held until secret_load or reset.
REQ-024 guess_valid outside READY SHALL be ignored, with no buffering.
REQ-025 secret_load SHALL be honoured in every state, captures secret, clears attempts/exact/partial/win/lose, enters READY.
REQ-026 secret_load coinciding with guess_valid SHALL win; the guess is discarded.
REQ-027 secret_load during EXACT/COLOR/REPORT SHALL abort scoring; no score_valid pulse follows; attempts not incremented.
REQ-028 Duplicate colours SHALL be legal in both secret and guess.

Reset
REQ-029 RESET_N low SHALL asynchronously force IDLE, secret=0, all outputs 0 (guess_ready, score_valid, exact, partial, attempts, win, lose).
REQ-030 Reset during scoring SHALL discard the in-flight guess; no score_valid after release.
REQ-031 The first state change after RESET_N release SHALL occur on the first rising edge with RESET_N high.

Structure
REQ-032 Package mastermind_pkg SHALL hold COLOR_W=3, NUM_DIGITS=4, NUM_COLORS=8, a code typedef (4 x COLOR_W), and the state enum.
REQ-033 Sub-module mastermind_color_count SHALL return the occurrences (0..4) of a given colour in a 12-bit code, instantiated once for secret and once for guess.

Verification
REQ-034 secret d0..d3=0,1,2,3; guess 0,1,2,3 -> exact=4, partial=0, attempts=1, win=1, guess_ready stays 0.
REQ-035 secret 0,1,2,3; guess 3,2,1,0 -> exact=0, partial=4, score_valid 12 edges after accept, back to READY.
REQ-036 secret 1,1,2,2; guess 1,2,1,5 -> exact=1, partial=2.
REQ-037 MAX_GUESSES=8, eight guesses 7,7,7,7 against 0,1,2,3 -> each exact=0, partial=0; after 8th lose=1, attempts=8, guess_ready=0; ninth guess_valid ignored.
REQ-038 secret_load issued 5 edges after a guess is accepted -> no score_valid, attempts=0, guess_ready=1 next cycle; simultaneous guess_valid discarded.
REQ-039 RESET_N pulsed low mid-COLOR -> all outputs 0 immediately, IDLE, guess_ready=0 until secret_load.
